// File: rtl/dts_align_ctrl.sv
// Closed-loop alignment controller: measures each stream's sync offset against stream 0 and
// pulses advance/delay until all land within one step. Define DTS_ALIGN_CTRL_RELOCK_EN for continuous re-monitoring after lock.
module dts_align_ctrl #(
  parameter int N_STREAMS       = 4,
  parameter int MUX_FACTOR_BITS = 0,
  parameter int MAX_OFFSET      = 15,
  parameter int PULSE_LEN       = 4,
  parameter int SETTLE_CYCLES   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N_STREAMS-1:0] sync,
  output logic [N_STREAMS-1:0] advance,
  output logic [N_STREAMS-1:0] delay,
  output logic                 locked,
  output logic                 missing,
  output logic [15:0]          adjust_count
);

  localparam int WIN_LAST = 2 * MAX_OFFSET;
  localparam int CW       = (WIN_LAST > 0) ? $clog2(WIN_LAST + 1) : 1;
  localparam int OW       = CW + 1;
  localparam int STEP     = 1 << MUX_FACTOR_BITS;
  localparam int TMAX     = (SETTLE_CYCLES > PULSE_LEN) ? SETTLE_CYCLES : PULSE_LEN;
  localparam int TW       = $clog2(TMAX + 1);

  localparam logic [CW-1:0] WIN_LAST_C  = CW'(WIN_LAST);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [TW-1:0] TIM_ONE     = TW'(1);
  localparam logic [TW-1:0] PULSE_LAST  = TW'(PULSE_LEN - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MEASURE = 3'd1,
    ST_EVAL    = 3'd2,
    ST_ADJUST  = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_LOCKED  = 3'd5
  } state_t;

  state_t               state_r;
  logic [N_STREAMS-1:0] advance_r;
  logic [N_STREAMS-1:0] delay_r;
  logic                 locked_r;
  logic                 missing_r;
  logic [15:0]          adjust_count_r;
  logic [N_STREAMS-1:0] cap_r;
  logic [CW-1:0]        t_r [N_STREAMS];
  logic                 win_open_r;
  logic [CW-1:0]        win_cnt_r;
  logic [TW-1:0]        timer_r;

  logic signed [OW-1:0] off_s [N_STREAMS];
  logic [N_STREAMS-1:0] adv_mark_s;
  logic [N_STREAMS-1:0] dly_mark_s;
  logic                 all_cap_s;
  logic [CW-1:0]        cap_cnt_s;

  assign advance      = advance_r;
  assign delay        = delay_r;
  assign locked       = locked_r;
  assign missing      = missing_r;
  assign adjust_count = adjust_count_r;

  // Offset of each stream relative to stream 0 and the resulting step marks.
  always_comb begin
    adv_mark_s = {N_STREAMS{1'b0}};
    dly_mark_s = {N_STREAMS{1'b0}};
    for (int i = 0; i < N_STREAMS; i++) begin
      off_s[i] = $signed({1'b0, t_r[i]}) - $signed({1'b0, t_r[0]});
      if (i == 0) begin
        adv_mark_s[i] = 1'b0;
        dly_mark_s[i] = 1'b0;
      end else if (int'(off_s[i]) >= STEP) begin
        adv_mark_s[i] = 1'b1;
        dly_mark_s[i] = 1'b0;
      end else if (int'(off_s[i]) <= -STEP) begin
        adv_mark_s[i] = 1'b0;
        dly_mark_s[i] = 1'b1;
      end else begin
        adv_mark_s[i] = 1'b0;
        dly_mark_s[i] = 1'b0;
      end
    end
    all_cap_s = &cap_r;
    // The opening sync is stamped 0 even though the counter has not started yet.
    if (win_open_r) begin
      cap_cnt_s = win_cnt_r;
    end else begin
      cap_cnt_s = {CW{1'b0}};
    end
  end

  // Control FSM with registered advance/delay/locked/missing outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      advance_r      <= {N_STREAMS{1'b0}};
      delay_r        <= {N_STREAMS{1'b0}};
      locked_r       <= 1'b0;
      missing_r      <= 1'b0;
      adjust_count_r <= 16'h0000;
      cap_r          <= {N_STREAMS{1'b0}};
      win_open_r     <= 1'b0;
      win_cnt_r      <= {CW{1'b0}};
      timer_r        <= {TW{1'b0}};
      for (int i = 0; i < N_STREAMS; i++) t_r[i] <= {CW{1'b0}};
    end else if (!en) begin
      state_r    <= ST_IDLE;
      advance_r  <= {N_STREAMS{1'b0}};
      delay_r    <= {N_STREAMS{1'b0}};
      locked_r   <= 1'b0;
      missing_r  <= 1'b0;
      cap_r      <= {N_STREAMS{1'b0}};
      win_open_r <= 1'b0;
      win_cnt_r  <= {CW{1'b0}};
      timer_r    <= {TW{1'b0}};
    end else begin
      missing_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cap_r      <= {N_STREAMS{1'b0}};
          win_open_r <= 1'b0;
          win_cnt_r  <= {CW{1'b0}};
          state_r    <= ST_MEASURE;
        end
        ST_MEASURE: begin
          if (win_open_r || (|sync)) begin
            win_open_r <= 1'b1;
            for (int i = 0; i < N_STREAMS; i++) begin
              if (sync[i] && !cap_r[i]) begin
                cap_r[i] <= 1'b1;
                t_r[i]   <= cap_cnt_s;
              end
            end
            if (cap_cnt_s == WIN_LAST_C) begin
              state_r <= ST_EVAL;
            end else begin
              win_cnt_r <= cap_cnt_s + CNT_ONE;
            end
          end
        end
        ST_EVAL: begin
          cap_r      <= {N_STREAMS{1'b0}};
          win_open_r <= 1'b0;
          win_cnt_r  <= {CW{1'b0}};
          timer_r    <= {TW{1'b0}};
          if (!all_cap_s) begin
            missing_r <= 1'b1;
            locked_r  <= 1'b0;
            state_r   <= ST_MEASURE;
          end else if ((adv_mark_s == {N_STREAMS{1'b0}}) && (dly_mark_s == {N_STREAMS{1'b0}})) begin
            locked_r <= 1'b1;
            state_r  <= ST_LOCKED;
          end else begin
            advance_r <= adv_mark_s;
            delay_r   <= dly_mark_s;
            locked_r  <= 1'b0;
            if (adjust_count_r != 16'hFFFF) begin
              adjust_count_r <= adjust_count_r + 16'd1;
            end
            state_r <= ST_ADJUST;
          end
        end
        ST_ADJUST: begin
          if (timer_r == PULSE_LAST) begin
            advance_r <= {N_STREAMS{1'b0}};
            delay_r   <= {N_STREAMS{1'b0}};
            timer_r   <= {TW{1'b0}};
            state_r   <= ST_SETTLE;
          end else begin
            timer_r <= timer_r + TIM_ONE;
          end
        end
        ST_SETTLE: begin
          if (timer_r == SETTLE_LAST) begin
            timer_r <= {TW{1'b0}};
            state_r <= ST_MEASURE;
          end else begin
            timer_r <= timer_r + TIM_ONE;
          end
        end
        ST_LOCKED: begin
`ifdef DTS_ALIGN_CTRL_RELOCK_EN
          if (timer_r == SETTLE_LAST) begin
            timer_r <= {TW{1'b0}};
            state_r <= ST_MEASURE;
          end else begin
            timer_r <= timer_r + TIM_ONE;
          end
`else
          state_r <= ST_LOCKED;
`endif
        end
        default: begin
          advance_r <= {N_STREAMS{1'b0}};
          delay_r   <= {N_STREAMS{1'b0}};
          locked_r  <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
